// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the hazard unit
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_ALT = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // Two-level priority pick: the nearer producer wins over the farther one.
    function automatic fwd_sel_t fwd_pick(
        input logic     hit_near,
        input fwd_sel_t sel_near,
        input logic     hit_far,
        input fwd_sel_t sel_far
    );
        if (hit_near) begin
            return sel_near;
        end else if (hit_far) begin
            return sel_far;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_div_seq.sv
// rtl/hazard_div_seq.sv - divider occupancy sequencer (IDLE/BUSY/DONE with down-counter)
module hazard_div_seq
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 33
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_INIT = CW'(DIV_CYCLES - 2);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // An exception in M kills the divide and also swallows a same-cycle start.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - forwarding, stall/flush and divider-stall control; HILO_FWD_EN enables HI/LO forwarding
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 33
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              hireadD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              hilowriteE,
    input  logic              divstartE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              hilowriteM,
    input  logic              exceptM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic [1:0]        forwardaD,
    output logic [1:0]        forwardbD,
    output logic [1:0]        forwardhiloE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              div_busy
);

    logic div_done_unused;
    logic hilo_stall;
    logic e_hits_d, m_hits_d;
    logic loaduse_stall, branch_stall, stall_d_raw;

    hazard_div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk    (clk),
        .resetn (resetn),
        .start  (divstartE),
        .abort  (exceptM),
        .busy   (div_busy),
        .done   (div_done_unused)
    );

    function automatic logic tag_hit(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] dst,
        input logic              wr
    );
        return wr && (src != '0) && (src == dst);
    endfunction

`ifdef HILO_FWD_EN
    logic hilo_w_q, hilo_w_d;
    logic hilo_unused;

    always_comb begin
        hilo_w_d = hilowriteM & ~exceptM;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hilo_w_q <= 1'b0;
        end else begin
            hilo_w_q <= hilo_w_d;
        end
    end

    assign hilo_unused  = hireadD ^ hilowriteE;
    assign hilo_stall   = 1'b0;
    assign forwardhiloE = fwd_pick(hilowriteM, FWD_M, hilo_w_q, FWD_ALT);
`else
    assign hilo_stall   = hireadD & (hilowriteE | hilowriteM);
    assign forwardhiloE = FWD_RF;
`endif

    always_comb begin
        forwardaE = fwd_pick(tag_hit(rsE, writeregM, regwriteM), FWD_M,
                             tag_hit(rsE, writeregW, regwriteW), FWD_ALT);
        forwardbE = fwd_pick(tag_hit(rtE, writeregM, regwriteM), FWD_M,
                             tag_hit(rtE, writeregW, regwriteW), FWD_ALT);
        forwardaD = fwd_pick(tag_hit(rsD, writeregE, regwriteE), FWD_ALT,
                             tag_hit(rsD, writeregM, regwriteM), FWD_M);
        forwardbD = fwd_pick(tag_hit(rtD, writeregE, regwriteE), FWD_ALT,
                             tag_hit(rtD, writeregM, regwriteM), FWD_M);
    end

    always_comb begin
        e_hits_d = (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
        m_hits_d = (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));

        loaduse_stall = memtoregE & regwriteE & e_hits_d;
        branch_stall  = branchD & ((regwriteE & e_hits_d) | (memtoregM & m_hits_d));
        stall_d_raw   = loaduse_stall | branch_stall | hilo_stall | div_busy;

        stallD = stall_d_raw;
        stallF = stall_d_raw;
        stallE = div_busy;
        flushE = stall_d_raw & ~div_busy;
        flushM = div_busy;
        flushW = 1'b0;
        // Exception wins over everything: squash E/M/W and let nothing stall.
        if (exceptM) begin
            stallD = 1'b0;
            stallF = 1'b0;
            stallE = 1'b0;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end
    end

endmodule
